fft_frame_loader: RTL and testbench

FFT_FRAME_LOADER -- requirements
Module: fft_frame_loader

---
 rtl/fft_frame_loader.sv | 86 ++++++++
 tb/tb_fft_frame_loader.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_frame_loader.sv
// Collects N complex samples from a valid/ready stream into a parallel frame for the FFT.
// Define FFT_FRAME_LOADER_BITREV_EN to store transfer k in slot bitrev(k) instead of slot k.
module fft_frame_loader #(
    parameter int N = 16,
    parameter int W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic signed [W:0] s_re,
    input  logic signed [W:0] s_im,
    input  logic              s_sof,
    output logic signed [W:0] x [2*N],
    output logic              frame_valid,
    input  logic              frame_ack,
    output logic              resync
);
    localparam int LG = $clog2(N);

    typedef enum logic {FILL, HOLD} state_t;

    state_t        state;
    logic [LG-1:0] idx;
    logic [LG-1:0] slot;

`ifdef FFT_FRAME_LOADER_BITREV_EN
    function automatic logic [LG-1:0] bitrev(input logic [LG-1:0] v);
        logic [LG-1:0] r;
        for (int i = 0; i < LG; i++) r[i] = v[LG-1-i];
        return r;
    endfunction

    // A start-of-frame sample always lands in slot 0, which bitrev maps to itself.
    assign slot = s_sof ? '0 : bitrev(idx);
`else
    assign slot = s_sof ? '0 : idx;
`endif

    // NOTE: every sequential target uses <= so all registers update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= FILL;
            idx         <= '0;
            s_ready     <= 1'b1;
            frame_valid <= 1'b0;
            resync      <= 1'b0;
            // NOTE: the frame store is reset because stale samples must never reach the FFT.
            for (int i = 0; i < 2*N; i++) x[i] <= '0;
        end else begin
            resync <= 1'b0;
            case (state)
                FILL: begin
                    if (s_valid) begin
                        x[{1'b0, slot}] <= s_re;
                        x[{1'b1, slot}] <= s_im;
                        if (s_sof) begin
                            idx    <= LG'(1);
                            resync <= (idx != '0);
                        end else begin
                            idx <= idx + LG'(1);
                            if (idx == LG'(N-1)) begin
                                state       <= HOLD;
                                s_ready     <= 1'b0;
                                frame_valid <= 1'b1;
                            end
                        end
                    end
                end
                HOLD: begin
                    if (frame_ack) begin
                        state       <= FILL;
                        s_ready     <= 1'b1;
                        frame_valid <= 1'b0;
                    end
                end
                default: begin
                    state       <= FILL;
                    s_ready     <= 1'b1;
                    frame_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fft_frame_loader.sv
// Scoreboard bench for fft_frame_loader: directed streams, expected frames queued, monitor compares.
// Expectations follow FFT_FRAME_LOADER_BITREV_EN when it is defined.
module tb_fft_frame_loader;
    localparam int N  = 16;
    localparam int W  = 16;
    localparam int FW = 2*N*(W+1);

    typedef logic [FW-1:0] frame_t;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              s_valid = 1'b0;
    logic              s_sof = 1'b0;
    logic              frame_ack = 1'b0;
    logic signed [W:0] s_re = '0;
    logic signed [W:0] s_im = '0;
    logic              s_ready, frame_valid, resync;
    logic signed [W:0] x [2*N];

    logic              s_valid8 = 1'b0;
    logic signed [W:0] s_re8 = '0;
    logic              s_ready8, fv8, rs8;
    logic signed [W:0] x8 [16];

    fft_frame_loader #(.N(N), .W(W)) dut (
        .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready),
        .s_re(s_re), .s_im(s_im), .s_sof(s_sof), .x(x),
        .frame_valid(frame_valid), .frame_ack(frame_ack), .resync(resync)
    );

    fft_frame_loader #(.N(8), .W(W)) dut8 (
        .clk(clk), .rst_n(rst_n), .s_valid(s_valid8), .s_ready(s_ready8),
        .s_re(s_re8), .s_im(s_re8), .s_sof(1'b0), .x(x8),
        .frame_valid(fv8), .frame_ack(1'b0), .resync(rs8)
    );

    always #5 clk = ~clk;

    int                n_cmp = 0;
    int                n_bad = 0;
    frame_t            exp_q[$];
    logic signed [W:0] m_x [2*N];
    int                m_idx = 0;
    int                last_wait = 0;
    bit                fv_q = 1'b0;
    frame_t            mon_exp;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_x(input string name, input frame_t act, input frame_t exp);
        int bad_i;
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            bad_i = 0;
            for (int i = 2*N-1; i >= 0; i--)
                if (act[i*(W+1) +: (W+1)] !== exp[i*(W+1) +: (W+1)]) bad_i = i;
            $display("FAIL %s: x[%0d] got 0x%0h expected 0x%0h", name, bad_i,
                     act[bad_i*(W+1) +: (W+1)], exp[bad_i*(W+1) +: (W+1)]);
        end
    endtask

    function automatic frame_t pack_dut();
        frame_t f;
        for (int i = 0; i < 2*N; i++) f[i*(W+1) +: (W+1)] = x[i];
        return f;
    endfunction

    function automatic frame_t pack_model();
        frame_t f;
        for (int i = 0; i < 2*N; i++) f[i*(W+1) +: (W+1)] = m_x[i];
        return f;
    endfunction

    function automatic int slot_of(input int k);
        logic [3:0] v;
        v = 4'(k);
`ifdef FFT_FRAME_LOADER_BITREV_EN
        return int'({v[0], v[1], v[2], v[3]});
`else
        return int'(v);
`endif
    endfunction

    // Offers one sample (s_valid stays high afterwards) and predicts its effect.
    task automatic send(input logic signed [W:0] re, input logic signed [W:0] im, input bit sof);
        int n;
        int s;
        bit exp_rs;
        bit exp_fv;
        n = 0;
        s_valid = 1'b1;
        s_re = re;
        s_im = im;
        s_sof = sof;
        while (!s_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        last_wait = n;
        if (!s_ready) begin
            n_cmp++;
            n_bad++;
            $display("FAIL send_timeout: s_ready got 0 expected 1 within 50 cycles");
            return;
        end
        exp_rs = sof && (m_idx != 0);
        exp_fv = 1'b0;
        if (sof) begin
            m_x[0] = re;
            m_x[N] = im;
            m_idx = 1;
        end else begin
            s = slot_of(m_idx);
            m_x[s] = re;
            m_x[N+s] = im;
            m_idx++;
            if (m_idx == N) begin
                m_idx = 0;
                exp_fv = 1'b1;
                exp_q.push_back(pack_model());
            end
        end
        @(negedge clk);
        s_sof = 1'b0;
        check("resync", 32'(resync), 32'(exp_rs));
        check("frame_valid", 32'(frame_valid), 32'(exp_fv));
        check("s_ready", 32'(s_ready), 32'(!exp_fv));
    endtask

    task automatic ack();
        s_valid = 1'b0;
        frame_ack = 1'b1;
        @(negedge clk);
        frame_ack = 1'b0;
        check("ack_s_ready", 32'(s_ready), 32'd1);
        check("ack_frame_valid", 32'(frame_valid), 32'd0);
    endtask

    // Monitor: every rising frame_valid consumes one expected frame.
    always @(negedge clk) begin
        if (!rst_n) begin
            fv_q = 1'b0;
        end else begin
            if (frame_valid && !fv_q) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL frame_unexpected: frame_valid got 1 expected 0");
                end else begin
                    mon_exp = exp_q.pop_front();
                    check_x("frame", pack_dut(), mon_exp);
                end
            end
            fv_q = frame_valid;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time got 200000 expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int exp8 [8];
`ifdef FFT_FRAME_LOADER_BITREV_EN
        exp8 = '{0, 4, 2, 6, 1, 5, 3, 7};
`else
        exp8 = '{0, 1, 2, 3, 4, 5, 6, 7};
`endif
        for (int i = 0; i < 2*N; i++) m_x[i] = '0;

        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        check("rst_s_ready", 32'(s_ready), 32'd1);
        check("rst_frame_valid", 32'(frame_valid), 32'd0);
        check("rst_resync", 32'(resync), 32'd0);
        check_x("rst_x", pack_dut(), '0);

        // Ramp frame with s_valid held high.
        for (int k = 0; k < 16; k++) send(17'(k << 8), 17'((15 - k) << 8), 1'b0);
`ifndef FFT_FRAME_LOADER_BITREV_EN
        check("ramp_x3", 32'(x[3]), 32'h0300);
        check("ramp_x19", 32'(x[19]), 32'h0C00);
`endif

        // HOLD ignores s_valid; ack reopens and the next sample lands in slot 0.
        s_re = 17'h1234;
        s_im = 17'h0555;
        repeat (5) @(negedge clk);
        check_x("hold_stable", pack_dut(), pack_model());
        check("hold_s_ready", 32'(s_ready), 32'd0);
        frame_ack = 1'b1;
        @(negedge clk);
        frame_ack = 1'b0;
        check("hold_ack_s_ready", 32'(s_ready), 32'd1);
        send(17'h0A00, 17'h0B00, 1'b0);
        check("after_hold_x0", 32'(x[0]), 32'h0A00);

        // Resync after 6 transfers, then 15 more complete the frame.
        for (int k = 1; k < 6; k++) send(17'(k * 3), 17'(k * 5), 1'b0);
        send(17'h7F00, 17'h0100, 1'b1);
        check("resync_x0", 32'(x[0]), 32'h7F00);
        check("resync_x16", 32'(x[16]), 32'h0100);
        for (int k = 1; k < 16; k++) send(17'(k + 200), 17'(k + 300), 1'b0);
        ack();

        // s_sof on the last slot wins; s_sof without s_valid does nothing.
        for (int k = 0; k < 15; k++) send(17'(k + 40), 17'(k + 80), 1'b0);
        send(17'h0111, 17'h0222, 1'b1);
        s_valid = 1'b0;
        s_sof = 1'b1;
        @(negedge clk);
        s_sof = 1'b0;
        check("sof_no_valid_resync", 32'(resync), 32'd0);
        check("sof_no_valid_x0", 32'(x[0]), 32'h0111);
        for (int k = 1; k < 16; k++) send(17'(k + 500), 17'(k + 600), 1'b0);
        ack();

        // Asynchronous reset mid-frame.
        for (int k = 0; k < 9; k++) send(17'(k + 7), 17'(k + 9), 1'b0);
        s_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_frame_valid", 32'(frame_valid), 32'd0);
        check_x("async_rst_x", pack_dut(), '0);
        for (int i = 0; i < 2*N; i++) m_x[i] = '0;
        m_idx = 0;
        @(negedge clk);
        rst_n = 1'b1;
        send(17'h0555, 17'h0666, 1'b0);
        check("post_rst_x0", 32'(x[0]), 32'h0555);
        for (int k = 1; k < 16; k++) send(17'(k + 900), 17'(k + 950), 1'b0);

        // Back-to-back frames with frame_ack tied high: one bubble only.
        s_valid = 1'b0;
        frame_ack = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 32; k++) begin
            send(17'(k * 16 + 1), 17'(k * 16 + 2), 1'b0);
            check("b2b_wait", 32'(last_wait), (k == 16) ? 32'd1 : 32'd0);
        end
        s_valid = 1'b0;
        @(negedge clk);
        frame_ack = 1'b0;
        check("b2b_done_s_ready", 32'(s_ready), 32'd1);

        // Eight-point instance: slot order for re = 0..7.
        s_valid8 = 1'b1;
        for (int k = 0; k < 8; k++) begin
            s_re8 = 17'(k);
            @(negedge clk);
        end
        s_valid8 = 1'b0;
        check("n8_frame_valid", 32'(fv8), 32'd1);
        for (int i = 0; i < 8; i++) check($sformatf("n8_x%0d", i), 32'(x8[i]), 32'(exp8[i]));

        @(negedge clk);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
